err_rcvr: RTL

//  Responder end of the 4-phase err_req/err_ack handshake driven by the error manager.

---
 rtl/err_rcvr_pkg.sv | 11 +
 rtl/err_rcvr_fifo.sv | 64 ++++++
 rtl/err_rcvr.sv | 99 +++++++++
 3 files changed

// File: rtl/err_rcvr_pkg.sv
// Shared definitions for the error receiver: error word width and handshake FSM states.
package err_rcvr_pkg;

    localparam int ERR_W = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/err_rcvr_fifo.sv
// First-word-fall-through FIFO holding received error words; head word is 0 when empty.
module err_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int ERR_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [ERR_W-1:0]      din,
    input  logic                  rd,
    output logic [ERR_W-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

    logic [ERR_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  do_rd;
    logic                  do_wr;

    // The count never exceeds DEPTH, so its MSB alone flags a full FIFO.
    assign full  = cnt[DEPTH_LOG2];
    assign empty = (cnt == '0);
    assign count = cnt;

    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);

    assign dout = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_rd) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/err_rcvr.sv
// Responder side of the 4-phase err_req/err_ack handshake; queues each error word and counts them.
module err_rcvr
    import err_rcvr_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  err_req,
    input  logic [ERR_W-1:0]      err_in,
    output logic                  err_ack,
    input  logic                  rd_en,
    output logic [ERR_W-1:0]      rd_data,
    output logic                  rd_empty,
    output logic [DEPTH_LOG2:0]   rd_count,
    output logic                  err_pending,
    output logic [CNT_W-1:0]      err_total,
    input  logic                  clr_total
);

    state_t     state;
    state_t     next_state;
    logic       push;
    logic       accept;
    logic       full;
    logic       empty;
    logic [CNT_W-1:0] total;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // A pop in the same cycle frees the slot the new word lands in.
    assign accept = ~full | rd_en;

    always_comb begin
        next_state = state;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                if (err_req && accept) begin
                    push       = 1'b1;
                    next_state = S_ACK;
                end
            end
            S_ACK: begin
                if (!err_req) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            err_ack <= 1'b0;
        end else begin
            state   <= next_state;
            err_ack <= (next_state == S_ACK);
        end
    end

    // Clear wins over the old value but still counts a word arriving on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= '0;
        end else if (clr_total) begin
            total <= push ? CNT_W'(1) : '0;
        end else if (push) begin
            total <= sat_inc(total);
        end
    end

    err_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .ERR_W      (ERR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (push),
        .din   (err_in),
        .rd    (rd_en),
        .dout  (rd_data),
        .empty (empty),
        .full  (full),
        .count (rd_count)
    );

    assign rd_empty    = empty;
    assign err_pending = ~empty;
    assign err_total   = total;

endmodule
